// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 demultiplexer with a one-entry skid buffer per channel.
// A source word is steered by in_sel into one of four independent output
// buffers. Each buffer has its own valid/ready handshake, so a stalled
// consumer only blocks source words that target its channel.
// Optional build macro DEMUX4_BUF_CNT_EN adds four 8-bit per-channel accept
// counters on xfer_cnt. Without it, xfer_cnt is tied to zero.

module demux4_buf_ch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;

    // State register. Reset drops any buffered word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    // A load always leaves the channel FULL, even when it drains in the
    // same cycle. A drain with no load empties it.
    always_comb begin
        w_state_nxt = r_state;
        if (i_load)
            w_state_nxt = FULL;
        else if (r_state == FULL && i_ready)
            w_state_nxt = EMPTY;
    end

    // Data is captured only on load, so it stays stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_data <= '0;
        else if (i_load) r_data <= i_data;
    end

    assign o_valid = (r_state == FULL);
    assign o_empty = (r_state == EMPTY);
    assign o_data  = r_data;

endmodule

module demux4_buf #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic               busy,
    output logic [31:0]        xfer_cnt
);

    logic [3:0]            w_empty;
    logic [3:0]            w_load;
    logic [3:0][WIDTH-1:0] w_data;
    logic                  w_accept;

    // Ready depends only on the selected channel, never on in_valid.
    assign in_ready = w_empty[in_sel] | out_ready[in_sel];
    assign w_accept = in_valid & in_ready;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        assign w_load[g] = w_accept && (in_sel == 2'(g));

        demux4_buf_ch #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_data  (in_data),
            .i_ready (out_ready[g]),
            .o_valid (out_valid[g]),
            .o_empty (w_empty[g]),
            .o_data  (w_data[g])
        );
    end

    assign out_data = w_data;
    assign busy     = |out_valid;

`ifdef DEMUX4_BUF_CNT_EN
    logic [3:0][7:0] r_cnt;

    // Per-channel accept counters, wrapping naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (w_load[i]) r_cnt[i] <= r_cnt[i] + 8'd1;
        end
    end

    assign xfer_cnt = r_cnt;
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_demux4_buf.sv
// Self-checking bench for demux4_buf: per-channel expected-word queues form
// the reference model. The driver pushes on predicted accepts, and a separate
// monitor pops and compares whenever a channel presents a word.

module tb_demux4_buf;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic [1:0]     in_sel = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready = '0;
    logic           busy;
    logic [31:0]    xfer_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[4][$];
    int           cnt_m[4];

    demux4_buf #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_cnt();
        logic [31:0] c = '0;
`ifdef DEMUX4_BUF_CNT_EN
        for (int i = 0; i < 4; i++) c[i*8 +: 8] = 8'(cnt_m[i]);
`endif
        return c;
    endfunction

    // One clock of stimulus: drive at negedge, check the model's view of the
    // current cycle, then record the predicted accept.
    task automatic cycle(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                         input logic [3:0] ordy);
        logic       rdy_m;
        logic [3:0] vld_m;
        @(negedge clk);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        #1;
        for (int i = 0; i < 4; i++) vld_m[i] = (exp_q[i].size() != 0);
        rdy_m = !vld_m[sel] || ordy[sel];
        chk("in_ready", 128'(in_ready), 128'(rdy_m));
        chk("out_valid", 128'(out_valid), 128'(vld_m));
        chk("busy", 128'(busy), 128'(|vld_m));
        chk("xfer_cnt", 128'(xfer_cnt), 128'(model_cnt()));
        if (v && rdy_m) begin
            exp_q[sel].push_back(d);
            cnt_m[sel] = (cnt_m[sel] + 1) % 256;
        end
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst out_data", 128'(out_data), 128'(0));
        chk("rst xfer_cnt", 128'(xfer_cnt), 128'(0));
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            cnt_m[i] = 0;
        end
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            out_ready = '0;
            #1;
            chk("rst in_ready", 128'(in_ready), 128'(1));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: while a channel holds a word, its slice must match the oldest
    // expected word; on a drain that word is retired.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    if (out_valid[i]) begin
                        if (exp_q[i].size() == 0) begin
                            chk("unexpected word", 128'(out_data[i*W +: W]), 128'hx);
                        end else begin
                            chk("out_data", 128'(out_data[i*W +: W]), 128'(exp_q[i][0]));
                            if (out_ready[i]) void'(exp_q[i].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        do_reset();

        // Single route with a 5-cycle stall, then drain.
        cycle(1, 2'd2, 32'hDEADBEEF, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 2'd0, 32'h0, 4'b0000);
            chk("stall valid", 128'(out_valid), 128'(4'b0100));
            chk("stall data", 128'(out_data[2*W +: W]), 128'(32'hDEADBEEF));
        end
        cycle(0, 2'd0, 32'h0, 4'b0100);
        cycle(0, 2'd0, 32'h0, 4'b0000);
        chk("drained", 128'(out_valid), 128'(0));

        // Backpressure isolation.
        cycle(1, 2'd1, 32'h11, 4'b0000);
        cycle(1, 2'd1, 32'h22, 4'b0000);
        chk("blocked ready", 128'(in_ready), 128'(0));
        cycle(1, 2'd3, 32'h5, 4'b0000);
        chk("other ready", 128'(in_ready), 128'(1));
        cycle(0, 2'd0, 32'h0, 4'b0000);
        chk("isolation valid", 128'(out_valid), 128'(4'b1010));
        cycle(0, 2'd0, 32'h0, 4'hF);

        // Streaming into one channel at full rate.
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 2'd0, W'(k), 4'hF);
            chk("stream ready", 128'(in_ready), 128'(1));
        end
        cycle(0, 2'd0, 32'h0, 4'hF);
        cycle(0, 2'd0, 32'h0, 4'hF);

        // Reset mid-operation with every channel full.
        for (int s = 0; s < 4; s++) cycle(1, 2'(s), 32'hA0 + W'(s), 4'b0000);
        cycle(0, 2'd0, 32'h0, 4'b0000);
        chk("all full", 128'(out_valid), 128'(4'hF));
        do_reset();
        for (int k = 0; k < 3; k++) cycle(0, 2'd0, 32'h0, 4'hF);

        // Randomized traffic.
        for (int k = 0; k < 600; k++)
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, 4'($urandom));
        for (int k = 0; k < 3; k++) cycle(0, 2'd0, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) chk("queue empty", 128'(exp_q[i].size()), 128'(0));

        // Counter wrap: 257 accepts into channel 3.
        do_reset();
        for (int k = 0; k < 257; k++) cycle(1, 2'd3, W'(k), 4'hF);
        cycle(0, 2'd0, 32'h0, 4'hF);
`ifdef DEMUX4_BUF_CNT_EN
        chk("cnt wrap", 128'(xfer_cnt), 128'(32'h0100_0000));
`else
        chk("cnt tied", 128'(xfer_cnt), 128'(0));
`endif
        cycle(0, 2'd0, 32'h0, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
